// File: rtl/rf_dump_reader.sv
// Streams a run of register-file words out over a valid/ready port, fetching
// two words per FETCH cycle through the register file's two combinational read ports.
module rf_dump_reader #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk_n,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW:0]   count,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [DW-1:0] rd_data_a,
    input  logic [DW-1:0] rd_data_b,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned NREG    = 2 ** AW;
    localparam logic [AW:0] REM_MAX = (AW + 1)'(NREG);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cur;
    logic [AW-1:0] cur_p1;
    logic [AW:0]   rem;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;

    // Address arithmetic wraps naturally in AW bits.
    assign cur_p1 = cur + AW'(1);

    // State register
    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; out_valid is high in both SEND states, so out_ready alone marks the handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (count == '0) ? DONE : FETCH;
            FETCH:   state_next = SEND0;
            SEND0:   if (out_ready) state_next = (rem == (AW + 1)'(1)) ? DONE : SEND1;
            SEND1:   if (out_ready) state_next = (rem == (AW + 1)'(2)) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        out_data  = '0;
        out_addr  = '0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            FETCH: begin
                rd_addr_a = cur;
                rd_addr_b = cur_p1;
            end
            SEND0: begin
                out_valid = 1'b1;
                out_data  = buf0;
                out_addr  = cur;
            end
            SEND1: begin
                out_valid = 1'b1;
                out_data  = buf1;
                out_addr  = cur_p1;
            end
            default: ;
        endcase
    end

    // Request capture, word buffers and pointer advance
    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            cur  <= '0;
            rem  <= '0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        cur <= first_addr;
                        rem <= (count > REM_MAX) ? REM_MAX : count;
                    end
                end
                FETCH: begin
                    // Port B is read even for an odd tail; that word is simply never sent.
                    buf0 <= rd_data_a;
                    buf1 <= rd_data_b;
                end
                SEND1: begin
                    if (out_ready && (rem != (AW + 1)'(2))) begin
                        cur <= cur + AW'(2);
                        rem <= rem - (AW + 1)'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader: a register-file model feeds the read ports,
// expected words are queued per request and popped on each output handshake.
module tb_rf_dump_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_n = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] first_addr = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [8];
    exp_t          sb [$];
    exp_t          e;
    int            total = 0;
    int            bad = 0;

    always #5 clk_n = ~clk_n;

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    rf_dump_reader #(.DW(DW), .AW(AW)) dut (
        .clk_n(clk_n), .rst(rst), .start(start), .first_addr(first_addr), .count(count),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Scoreboard: a handshake completes at the rising edge following this sample.
    always @(negedge clk_n) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %h@%0d, required no word", out_data, out_addr);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_addr !== e.addr) begin
                    bad++;
                    $display("FAIL sb_word: got %h@%0d, required %h@%0d", out_data, out_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [AW:0] c);
        @(posedge clk_n); #1;
        start = 1'b1; first_addr = a; count = c;
        @(posedge clk_n); #1;
        start = 1'b0;
    endtask

    task automatic push_run(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = a + AW'(i);
            sb.push_back({ad, rf[ad]});
        end
    endtask

    task automatic run_to_done(output int nbusy, output bit got, output bit hs_last);
        nbusy = 0; got = 1'b0; hs_last = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
            hs_last = (out_valid === 1'b1) && (out_ready === 1'b1);
            @(posedge clk_n); #1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, out_valid, out_data, out_addr, rd_addr_a, rd_addr_b} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got b%0b d%0b v%0b %h@%0d ra%0d rb%0d, required all 0",
                     busy, done, out_valid, out_data, out_addr, rd_addr_a, rd_addr_b);
        end
        @(posedge clk_n); @(posedge clk_n); #1;
        rst = 1'b0;
        @(posedge clk_n); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    task automatic test_full();
        int nb; bit got; bit hs;
        out_ready = 1'b1;
        push_run(3'd0, 8);
        issue(3'd0, 4'd8);
        run_to_done(nb, got, hs);
        total++;
        if (!got || nb != 12) begin
            bad++;
            $display("FAIL full_busy: got done=%0b busy_cycles=%0d, required 1 12", got, nb);
        end
        total++;
        if (!hs || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_done_timing: got hs_before=%0b busy=%0b, required 1 1", hs, busy);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL full_words_left: got %0d, required 0", sb.size());
        end
        @(posedge clk_n); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_addr_a !== '0 || rd_addr_b !== '0) begin
            bad++;
            $display("FAIL full_idle: got done=%0b busy=%0b ra=%0d rb=%0d, required 0 0 0 0",
                     done, busy, rd_addr_a, rd_addr_b);
        end
    endtask

    task automatic test_wrap();
        int nb; bit got; bit hs;
        push_run(3'd6, 4);
        issue(3'd6, 4'd4);
        run_to_done(nb, got, hs);
        total++;
        if (!got || nb != 6 || sb.size() != 0) begin
            bad++;
            $display("FAIL wrap: got done=%0b busy_cycles=%0d left=%0d, required 1 6 0", got, nb, sb.size());
        end
    endtask

    task automatic test_odd();
        int fetches; bit got;
        logic [AW-1:0] ra; logic [AW-1:0] rb;
        fetches = 0; got = 1'b0; ra = '0; rb = '0;
        push_run(3'd2, 3);
        issue(3'd2, 4'd3);
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1 && out_valid === 1'b0) begin
                fetches++;
                if (fetches == 2) begin
                    ra = rd_addr_a;
                    rb = rd_addr_b;
                end
            end
            @(posedge clk_n); #1;
        end
        total++;
        if (!got || fetches != 2) begin
            bad++;
            $display("FAIL odd_flow: got done=%0b fetches=%0d, required 1 2", got, fetches);
        end
        total++;
        if (ra !== 3'd4 || rb !== 3'd5) begin
            bad++;
            $display("FAIL odd_fetch_addr: got ra=%0d rb=%0d, required 4 5", ra, rb);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL odd_words_left: got %0d, required 0", sb.size());
        end
    endtask

    task automatic test_zero_count();
        issue(3'd5, 4'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: got done=%0b busy=%0b valid=%0b, required 1 1 0", done, busy, out_valid);
        end
        @(posedge clk_n); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: got done=%0b busy=%0b, required 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        int nb; bit got; bit hs; bit seen;
        seen = 1'b0;
        out_ready = 1'b0;
        push_run(3'd0, 8);
        issue(3'd0, 4'd8);
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_n); #1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall_first_valid: got no out_valid, required out_valid within 10 cycles");
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_addr !== 3'd0) begin
                bad++;
                $display("FAIL stall_hold%0d: got v%0b %h@%0d, required v1 1111@0", k, out_valid, out_data, out_addr);
            end
            if (k < 4) begin
                @(posedge clk_n); #1;
            end
        end
        out_ready = 1'b1;
        run_to_done(nb, got, hs);
        total++;
        if (!got || !hs || sb.size() != 0) begin
            bad++;
            $display("FAIL stall_finish: got done=%0b hs=%0b left=%0d, required 1 1 0", got, hs, sb.size());
        end
        @(posedge clk_n); #1;
    endtask

    task automatic test_reset_mid();
        int nb; bit got; bit hs; bit seen; bit spurious;
        seen = 1'b0; spurious = 1'b0;
        out_ready = 1'b1;
        push_run(3'd0, 1);
        issue(3'd0, 4'd8);
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1 && out_addr === 3'd1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_n); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (!seen || {busy, done, out_valid, out_data, out_addr, rd_addr_a, rd_addr_b} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got seen=%0b b%0b d%0b v%0b %h@%0d ra%0d rb%0d, required 1 and all 0",
                     seen, busy, done, out_valid, out_data, out_addr, rd_addr_a, rd_addr_b);
        end
        @(posedge clk_n); #1;
        if (done !== 1'b0) spurious = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_n); #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        total++;
        if (spurious || sb.size() != 0) begin
            bad++;
            $display("FAIL midrst_abort: got spurious=%0b left=%0d, required 0 0", spurious, sb.size());
        end
        push_run(3'd0, 2);
        issue(3'd0, 4'd2);
        run_to_done(nb, got, hs);
        total++;
        if (!got || nb != 3 || !hs || sb.size() != 0) begin
            bad++;
            $display("FAIL midrst_restart: got done=%0b busy_cycles=%0d hs=%0b left=%0d, required 1 3 1 0",
                     got, nb, hs, sb.size());
        end
    endtask

    initial begin
        rf[0] = 16'h1111; rf[1] = 16'h2222; rf[2] = 16'h4444; rf[3] = 16'h8888;
        rf[4] = 16'h9999; rf[5] = 16'haaaa; rf[6] = 16'hcccc; rf[7] = 16'hdddd;
        test_reset();
        test_full();
        test_wrap();
        test_odd();
        test_zero_count();
        test_stall();
        test_reset_mid();
        repeat (3) @(posedge clk_n);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
RF_DUMP_READER -- requirements
Module: rf_dump_reader

Interface
REQ-001 Parameter DW, default 16, SHALL set the register data width.
REQ-002 Parameter AW, default 3, SHALL set the register address width (2**AW registers).
REQ-003 Port clk_n, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: dump request, sampled only in IDLE.
REQ-006 Port first_addr, input, AW: first register to read, captured when start is accepted.
REQ-007 Port count, input, AW+1: number of words to read, captured when start is accepted.
REQ-008 Port rd_addr_a, output, AW: register file read port A address.
REQ-009 Port rd_addr_b, output, AW: register file read port B address.
REQ-010 Port rd_data_a, input, DW: register file port A data, combinational from rd_addr_a.
REQ-011 Port rd_data_b, input, DW: register file port B data, combinational from rd_addr_b.
REQ-012 Port out_data, output, DW: streamed register word.
REQ-013 Port out_addr, output, AW: source address of out_data.
REQ-014 Port out_valid, output, 1: out_data/out_addr valid.
REQ-015 Port out_ready, input, 1: sink accepts the word when out_valid and out_ready are high at a rising edge.
REQ-016 Port busy, output, 1: high from the cycle after start is accepted until the end of DONE.
REQ-017 Port done, output, 1: one-cycle pulse at the end of every accepted request.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, SEND0, SEND1 and DONE; all outputs SHALL be registered or decoded from registered state.
REQ-019 In IDLE, start=1 with count>0 SHALL capture cur=first_addr and rem=min(count, 2**AW), then go to FETCH.
REQ-020 In IDLE, start=1 with count=0 SHALL go directly to DONE without asserting out_valid.
REQ-021 In FETCH: rd_addr_a=cur and rd_addr_b=(cur+1) mod 2**AW; the next edge SHALL capture rd_data_a into buf0 and rd_data_b into buf1, then go to SEND0 (one cycle).
REQ-022 In SEND0: out_valid=1, out_data=buf0, out_addr=cur; on handshake, rem=1 SHALL go to DONE, otherwise go to SEND1.
REQ-023 In SEND1: out_valid=1, out_data=buf1, out_addr=cur+1 mod 2**AW; on handshake, rem=2 SHALL go to DONE, otherwise set cur=cur+2 mod 2**AW, rem=rem-2 and go to FETCH.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_addr and out_valid SHALL hold stable.
REQ-025 Address arithmetic SHALL wrap modulo 2**AW; after the last register comes register 0.
REQ-026 For odd rem, the final FETCH still reads port B, and that word SHALL be discarded.
REQ-027 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-028 start outside IDLE SHALL be ignored; there is no queuing.
REQ-029 In IDLE and DONE: rd_addr_a=0, rd_addr_b=0, out_valid=0.
REQ-030 With out_ready held at 1, each pair of words SHALL take 3 cycles (FETCH, SEND0, SEND1).

Reset
REQ-031 rst=1 SHALL immediately force IDLE and drive busy=0, done=0, out_valid=0, out_data=0, out_addr=0, rd_addr_a=0, rd_addr_b=0, with buf0, buf1, cur and rem all 0.
REQ-032 rst asserted mid-operation SHALL abort the request without a done pulse; the first start after rst deasserts SHALL be serviced normally.

Verification
REQ-033 RF preloaded 0..7 = 1111,2222,4444,8888,9999,aaaa,cccc,dddd; first_addr=0, count=8, out_ready=1 -> eight words in address order 0..7, then done one cycle after the last handshake; 12 busy cycles before DONE.
REQ-034 Same RF; first_addr=6, count=4 -> words cccc@6, dddd@7, 1111@0, 2222@1 (wrap-around).
REQ-035 first_addr=2, count=3 -> 4444@2, 8888@3, 9999@4, then done; second FETCH drives rd_addr_b=5 and aaaa is never output.
REQ-036 count=8, out_ready=0 for 5 cycles during the first SEND0 -> out_data=1111 and out_addr=0 stable for all 5 cycles; the sequence then completes unchanged.
REQ-037 count=0 -> done=1 and busy=1 exactly one cycle after start; out_valid never asserts.
REQ-038 rst pulsed while in SEND1 -> all outputs 0 at once, no done pulse; then first_addr=0, count=2 -> 1111@0, 2222@1, then done.
